// File: rtl/aes_key_expand.sv
// aes_key_expand: iterative AES-128 key schedule generator.
// Accepts one cipher key, then emits round keys 0..10 in order. Each key is
// derived in place from the previous one, so there is no key store.
// Build option AES_KEY_EXP_SHARED_SBOX_EN: one time-shared sbox with a
// 4-cycle COMPUTE state instead of four parallel sboxes with a 1-cycle one.

// AES forward substitution box, purely combinational table lookup.
module aes_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);
    // Rows are listed from entry 0 onward, so entry x lands at packed index 255-x.
    localparam logic [255:0][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_o = SBOX[~in_i];
endmodule

module aes_key_expand #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key_in,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_idx,
    output logic         busy
);
    generate
        if (NUM_ROUNDS != 10) begin : g_bad_rounds
            $error("aes_key_expand supports only NUM_ROUNDS = 10 (AES-128)");
        end
    endgenerate

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EMIT    = 2'd1,
        COMPUTE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [127:0] rk_q, rk_d;
    logic [3:0]   idx_q, idx_d;
    logic [7:0]   rcon_q, rcon_d;

    logic [31:0]  rot_w;
    logic [31:0]  sub_w;
    logic [31:0]  t_w;
    logic [31:0]  w0n, w1n, w2n, w3n;
    logic         compute_done;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // RotWord(w3): bytes (a,b,c,d) become (b,c,d,a).
    assign rot_w = {rk_q[23:0], rk_q[31:24]};

`ifdef AES_KEY_EXP_SHARED_SBOX_EN
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] tmp_q, tmp_d;
    logic [7:0]  sb_in, sb_out;

    aes_sbox u_sbox (
        .in_i  (sb_in),
        .out_o (sb_out)
    );

    // Select the rotated byte handled in this COMPUTE cycle and collect results.
    always_comb begin
        cnt_d = cnt_q;
        tmp_d = tmp_q;
        case (cnt_q)
            2'd0:    sb_in = rot_w[31:24];
            2'd1:    sb_in = rot_w[23:16];
            2'd2:    sb_in = rot_w[15:8];
            default: sb_in = rot_w[7:0];
        endcase
        if (state_q == COMPUTE) begin
            cnt_d = cnt_q + 2'd1;
            case (cnt_q)
                2'd0:    tmp_d[31:24] = sb_out;
                2'd1:    tmp_d[23:16] = sb_out;
                2'd2:    tmp_d[15:8]  = sb_out;
                default: tmp_d        = tmp_q;
            endcase
        end
    end

    // Byte counter is control (reset); the temp word is pure data.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
        end
        tmp_q <= tmp_d;
    end

    // Last byte goes straight from the sbox so the update lands on the 4th cycle.
    assign sub_w        = {tmp_q[31:8], sb_out};
    assign compute_done = (state_q == COMPUTE) && (cnt_q == 2'd3);
`else
    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .in_i  (rot_w[8*i +: 8]),
            .out_o (sub_w[8*i +: 8])
        );
    end

    assign compute_done = (state_q == COMPUTE);
`endif

    assign t_w = sub_w ^ {rcon_q, 24'h0};
    assign w0n = rk_q[127:96] ^ t_w;
    assign w1n = rk_q[95:64]  ^ w0n;
    assign w2n = rk_q[63:32]  ^ w1n;
    assign w3n = rk_q[31:0]   ^ w2n;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (key_valid) state_d = EMIT;
            EMIT:    if (rk_ready) state_d = (idx_q == LAST_IDX) ? IDLE : COMPUTE;
            COMPUTE: if (compute_done) state_d = EMIT;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        key_ready = (state_q == IDLE);
        rk_valid  = (state_q == EMIT);
        busy      = (state_q != IDLE);
    end

    // Key, index and rcon next values; rcon stops advancing once rk10 is formed.
    always_comb begin
        rk_d   = rk_q;
        idx_d  = idx_q;
        rcon_d = rcon_q;
        if ((state_q == IDLE) && key_valid) begin
            rk_d   = key_in;
            idx_d  = 4'd0;
            rcon_d = 8'h01;
        end else if (compute_done) begin
            rk_d   = {w0n, w1n, w2n, w3n};
            idx_d  = idx_q + 4'd1;
            rcon_d = (idx_q == LAST_IDX - 4'd1) ? rcon_q : xtime(rcon_q);
        end
    end

    // Round key, index and rcon registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rk_q   <= 128'h0;
            idx_q  <= 4'd0;
            rcon_q <= 8'h01;
        end else begin
            rk_q   <= rk_d;
            idx_q  <= idx_d;
            rcon_q <= rcon_d;
        end
    end

    assign rk_out = rk_q;
    assign rk_idx = idx_q;
endmodule

// File: tb/tb_aes_key_expand.sv
// Directed testbench for aes_key_expand using FIPS-197 and all-zero key vectors.
module tb_aes_key_expand;
    logic         clk = 1'b0;
    logic         rst;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] key_in;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx;
    logic         busy;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [127:0] exp_rk [11];
    logic         exp_en [11];

`ifdef AES_KEY_EXP_SHARED_SBOX_EN
    localparam int LAT10 = 51;
`else
    localparam int LAT10 = 21;
`endif
    localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam int BP_LEN = 7;

    aes_key_expand dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_in    (key_in),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk_out    (rk_out),
        .rk_idx    (rk_idx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] expv);
        n_chk++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic load_a1;
        exp_rk[0]  = KEY_A1;
        exp_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        exp_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        exp_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        exp_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        exp_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        exp_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        exp_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        exp_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        exp_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        exp_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        for (int i = 0; i < 11; i++) exp_en[i] = 1'b1;
    endtask

    task automatic load_zero;
        for (int i = 0; i < 11; i++) begin
            exp_rk[i] = 128'h0;
            exp_en[i] = 1'b0;
        end
        exp_en[0]  = 1'b1;
        exp_en[1]  = 1'b1;
        exp_en[10] = 1'b1;
        exp_rk[1]  = 128'h62636363626363636263636362636363;
        exp_rk[10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
    endtask

    // mode 0: plain, 1: backpressure at rk_idx 3, 2: foreign key offered at rk_idx 5
    task automatic run_sched(input int mode, input logic [127:0] key);
        int   start;
        int   n_hs;
        int   extra;
        logic done;
        logic intr;
        start = cyc;
        n_hs  = 0;
        done  = 1'b0;
        intr  = 1'b0;
        extra = (mode == 1) ? BP_LEN : 0;
        check("key_ready_at_offer", 128'(key_ready), 128'(1));
        key_valid = 1'b1;
        key_in    = key;
        rk_ready  = 1'b1;
        tick();
        key_valid = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            rk_ready  = 1'b1;
            key_valid = 1'b0;
            if (mode == 1 && rk_valid && rk_idx == 4'd3 && n_hs == 3) begin
                for (int h = 0; h < BP_LEN; h++) begin
                    rk_ready = 1'b0;
                    check("bp_rk_out", rk_out, exp_rk[3]);
                    check("bp_rk_idx", 128'(rk_idx), 128'(3));
                    check("bp_rk_valid", 128'(rk_valid), 128'(1));
                    check("bp_busy", 128'(busy), 128'(1));
                    tick();
                end
                rk_ready = 1'b1;
            end
            if (mode == 2 && rk_valid && rk_idx == 4'd5 && !intr) begin
                key_valid = 1'b1;
                key_in    = ~key;
                intr      = 1'b1;
                check("key_ready_while_busy", 128'(key_ready), 128'(0));
            end
            if (rk_valid && rk_ready) begin
                check("rk_idx_order", 128'(rk_idx), 128'(n_hs));
                check("busy_in_emit", 128'(busy), 128'(1));
                if (n_hs < 11 && exp_en[n_hs]) check($sformatf("rk%0d", n_hs), rk_out, exp_rk[n_hs]);
                if (rk_idx == 4'd10) begin
                    check("rk10_cycle", 128'(cyc - start), 128'(LAT10 + extra));
                    done = 1'b1;
                end
                n_hs++;
            end
            tick();
        end
        key_valid = 1'b0;
        check("sched_done", 128'(done), 128'(1));
        check("handshake_count", 128'(n_hs), 128'(11));
        check("idle_cycle", 128'(cyc - start), 128'(LAT10 + 1 + extra));
        check("key_ready_after", 128'(key_ready), 128'(1));
        check("busy_after", 128'(busy), 128'(0));
        check("rk_valid_after", 128'(rk_valid), 128'(0));
    endtask

    initial begin
        logic found;
        rst       = 1'b1;
        key_valid = 1'b0;
        key_in    = 128'h0;
        rk_ready  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_key_ready", 128'(key_ready), 128'(1));
        check("rst_rk_valid", 128'(rk_valid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_rk_idx", 128'(rk_idx), 128'(0));
        check("rst_rk_out", rk_out, 128'h0);

        // Stray rk_ready in IDLE does nothing.
        rk_ready = 1'b1;
        tick();
        check("idle_rk_ready_valid", 128'(rk_valid), 128'(0));
        check("idle_rk_ready_idx", 128'(rk_idx), 128'(0));

        load_a1();
        run_sched(0, KEY_A1);

        load_zero();
        run_sched(0, 128'h0);

        load_a1();
        run_sched(1, KEY_A1);

        load_a1();
        run_sched(2, KEY_A1);
        // Next key offered immediately at cycle 22 of the previous schedule.
        load_zero();
        run_sched(0, 128'h0);

        // Reset during COMPUTE at rk_idx 4.
        key_valid = 1'b1;
        key_in    = KEY_A1;
        rk_ready  = 1'b1;
        tick();
        key_valid = 1'b0;
        found     = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            if (rk_valid && rk_idx == 4'd4) found = 1'b1;
            tick();
        end
        check("rst_mid_found", 128'(found), 128'(1));
`ifdef AES_KEY_EXP_SHARED_SBOX_EN
        tick();
`endif
        check("pre_rst_valid", 128'(rk_valid), 128'(0));
        check("pre_rst_idx", 128'(rk_idx), 128'(4));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_rk_valid", 128'(rk_valid), 128'(0));
        check("mid_rst_busy", 128'(busy), 128'(0));
        check("mid_rst_key_ready", 128'(key_ready), 128'(1));
        check("mid_rst_rk_idx", 128'(rk_idx), 128'(0));
        check("mid_rst_rk_out", rk_out, 128'h0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("post_rst_no_valid", 128'(rk_valid), 128'(0));
        end
        load_a1();
        run_sched(0, KEY_A1);

        // rst and key_valid together: key must not be taken.
        rst       = 1'b1;
        key_valid = 1'b1;
        key_in    = KEY_A1;
        tick();
        rst       = 1'b0;
        key_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rst_key_rk_valid", 128'(rk_valid), 128'(0));
            check("rst_key_busy", 128'(busy), 128'(0));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
Iterative AES-128 key schedule generator that sits directly upstream of the round datapath and consumes the byte substitution table through its own sbox instances.
- Accepts one 128-bit cipher key per valid/ready handshake.
- Emits round keys 0..10 in order over a second valid/ready handshake.
- Computes each key from the previous one in place, so no 11-entry key store is needed.

Parameters:
NUM_ROUNDS, 10, number of round keys after round key 0; only 10 is supported (AES-128), and any other value is an elaboration error.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
key_valid  input  1  cipher key offered
key_ready  output  1  block idle and able to accept a key
key_in  input  128  cipher key; [127:120] is byte 0, w0 = [127:96]
rk_valid  output  1  rk_out/rk_idx hold a valid round key
rk_ready  input  1  consumer accepts round key
rk_out  output  128  round key; same byte order as key_in
rk_idx  output  4  round index of rk_out, 0..10
busy  output  1  high from key acceptance until the rk_idx=10 handshake completes

Behaviour:
- Reset is synchronous and active-high; there is one clock, clk.
- Reset values:
  - state = IDLE
  - rk_valid=0, rk_out=0, rk_idx=0, busy=0
  - key_ready=1 (key_ready is decoded from state == IDLE)
  - rcon register = 8'h01
- States: IDLE, EMIT, COMPUTE.
- IDLE:
  - key_ready=1.
  - On key_valid&&key_ready: register key_in into rk_out, set rk_idx=0, rcon=01, go to EMIT.
  - rk_valid rises on the next cycle (1-cycle latency).
- EMIT:
  - rk_valid=1.
  - rk_out and rk_idx are held stable until rk_ready.
  - On rk_valid&&rk_ready with rk_idx==10: go to IDLE, rk_valid=0, busy=0.
  - On rk_valid&&rk_ready otherwise: go to COMPUTE, rk_valid=0.
- COMPUTE, on the current key w0..w3:
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}, where RotWord(a,b,c,d) = (b,c,d,a).
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - On completion: rk_out <= {w0',w1',w2',w3'}, rk_idx++, rcon <= xtime(rcon), go to EMIT.
  - xtime means shift left by 1; if bit7 was set, XOR 8'h1b.
  - Resulting rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
- COMPUTE duration: 1 cycle with four parallel sboxes (default build).
- Timing with rk_ready tied high and key accepted at cycle 0:
  - Round key N is valid at cycle 2N+1; rk10 is valid at cycle 21.
  - key_ready is high again at cycle 22.
- key_valid while not IDLE: ignored, key_ready=0, no state change.
- rk_ready while rk_valid=0: ignored.
- Backpressure of any length in EMIT: outputs are frozen and no computation advances.
- rst asserted in any state, including mid-COMPUTE: next cycle is the reset values. The partial schedule is discarded and no further rk_valid pulses occur.
- rst and key_valid in the same cycle: rst wins and the key is not accepted.
- rk_idx never exceeds 10; rcon never advances past 36 for a single key.

Optional Feature:
Macro AES_KEY_EXP_SHARED_SBOX_EN.
- Defined:
  - A single sbox instance is time-shared.
  - COMPUTE lasts exactly 4 cycles; a 2-bit byte counter substitutes rotated bytes 0..3 of w3 into a 32-bit temp register.
  - w0'..w3' and the rcon update are applied on the 4th cycle.
  - Round key N is valid at cycle 1+5N; rk10 is valid at cycle 51; key_ready returns at cycle 52.
  - rst mid-count clears the counter.
- Undefined: four sbox instances and 1-cycle COMPUTE, as above.
- Port list and handshake semantics are identical in both builds.

Test Plan:
1. FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1:
   - rk0 equals the input key.
   - rk1 = a0fafe1788542cb123a339392a6c7605.
   - rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6, valid at cycle 21 (cycle 51 with AES_KEY_EXP_SHARED_SBOX_EN).
   - Exactly 11 handshakes occur.
2. All-zero key:
   - rk1 = 62636363626363636263636362636363.
   - rk10 = b4ef5bcb3e92e21123e951cf6f8f188e.
3. Backpressure, same key as 1:
   - Hold rk_ready=0 for 7 cycles while rk_idx=3.
   - rk_out and rk_idx stay stable, busy=1.
   - After release, all keys match scenario 1.
4. Key offered while busy:
   - Pulse key_valid with a different key at rk_idx=5.
   - key_ready=0 and the key is ignored; the sequence matches scenario 1.
   - A key offered after rk10 is accepted at cycle 22.
5. Reset during COMPUTE:
   - Assert rst for 1 cycle at rk_idx=4 during COMPUTE.
   - Next cycle: rk_valid=0, busy=0, key_ready=1, rk_idx=0.
   - A fresh key then produces the correct full schedule.
6. Simultaneous rst and key_valid in one cycle:
   - The key is not accepted, and rk_valid stays 0 for the following 3 cycles.
